simple_rsp_bfm: RTL and testbench
=================================

SIMPLE_RSP_BFM -- requirements
Module: simple_rsp_bfm

Interface
REQ-001 Parameter ACK_DELAY, default 2, cycles from req capture to ack assertion (0..15).
REQ-002 Parameter FIFO_DEPTH, default 4, entries in the receive buffer (power of two, 2..16).
REQ-003 clk  input  1  sole clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 req  input  1  request from the initiator, held high until ack is seen.
REQ-006 data  input  8  payload, valid while req is high.
REQ-007 ack  output  1  one-cycle acknowledge pulse to the initiator.
REQ-008 out_valid  output  1  receive buffer non-empty.
REQ-009 out_data  output  8  oldest buffered payload.
REQ-010 out_ready  input  1  consumer pop; pop occurs when out_valid and out_ready are both high.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 FSM states: IDLE, DELAY, ACK, RELEASE; ack is registered.
REQ-013 IDLE: req=1 and buffer not full -> push data into the buffer; load the delay counter with ACK_DELAY; go to DELAY, or go directly to ACK if ACK_DELAY=0.
REQ-014 IDLE: req=1 and buffer full -> stay in IDLE with ack low (backpressure); capture on the first cycle the buffer is not full.
REQ-015 DELAY: decrement the counter each cycle; enter ACK on the cycle the counter reaches 1.
REQ-016 ACK: ack=1 for exactly one cycle; next state is RELEASE.
REQ-017 RELEASE: wait for req=0, then return to IDLE; a request is never captured twice.
REQ-018 Latency: with req rising at edge N into an empty buffer, ack is high during cycle N+1+ACK_DELAY.
REQ-019 Buffer: FIFO_DEPTH-entry FIFO with wrap-around pointers and a count of width clog2(FIFO_DEPTH)+1; out_data is valid combinationally from the head.
REQ-020 Push and pop in the same cycle: both occur, count is unchanged, and this is legal when full (the pop frees the slot first).
REQ-021 Pop when empty is ignored; out_valid stays 0.
REQ-022 data is sampled only on the capture edge; later changes to data are ignored.

Reset
REQ-023 rst_n low: FSM=IDLE, ack=0, busy=0, pointers and count=0, out_valid=0, out_data=0, all counters=0, effective immediately.
REQ-024 Reset mid-handshake abandons the transaction; buffered data is discarded; after release, a still-high req is treated as a new request.

Configuration
REQ-025 Macro SIMPLE_RSP_BFM_STATS_EN defined: adds outputs req_count[15:0] (captures), ack_count[15:0] (ack pulses), stall_count[15:0] (IDLE cycles with req=1 and buffer full); counters saturate at 16'hFFFF.
REQ-026 Macro SIMPLE_RSP_BFM_STATS_EN undefined: these ports and their logic are absent; all other behaviour is identical.

Structure
REQ-027 Package simple_bfm_pkg holds the FSM state enum (rsp_state_t), the data width constant BFM_DATA_W=8, and the counter width constant BFM_CNT_W=16.
REQ-028 One sub-module, simple_bfm_fifo, implements the buffer; the FSM, delay counter and stats stay in simple_rsp_bfm.

Verification
REQ-029 ACK_DELAY=2, empty buffer; req=1 with data=8'hA5 at edge 10 -> ack high in cycle 13 only; out_valid=1 with out_data=8'hA5 from cycle 11.
REQ-030 FIFO_DEPTH=4, out_ready=0; 5 back-to-back requests -> 4 acked; 5th held with ack=0 and stall_count incrementing; one pop -> 5th captured the next cycle.
REQ-031 Full buffer; pop and new capture in the same cycle -> count stays 4; pop order is preserved across pointer wrap.
REQ-032 req held high for 6 cycles after ack -> FSM stays in RELEASE; req_count=1, ack_count=1.
REQ-033 rst_n asserted in DELAY -> ack never pulses, out_valid=0 immediately; req still high after release -> fresh capture.
REQ-034 ACK_DELAY=0 -> ack high in cycle N+1 after a req capture at edge N.

Source files
------------

// File: rtl/simple_bfm_pkg.sv
// Shared types and constants for the simple response BFM.
// Used by simple_rsp_bfm and simple_bfm_fifo.
package simple_bfm_pkg;

    localparam int BFM_DATA_W = 8;
    localparam int BFM_CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DELAY   = 2'd1,
        ACK     = 2'd2,
        RELEASE = 2'd3
    } rsp_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [BFM_CNT_W-1:0] sat_inc(input logic [BFM_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/simple_bfm_fifo.sv
// Receive buffer for simple_rsp_bfm: DEPTH-entry FIFO with wrap-around
// pointers. The head entry is presented combinationally; a pop and a push
// in the same cycle are both honoured, even when the buffer is full.
module simple_bfm_fifo
    import simple_bfm_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [BFM_DATA_W-1:0] push_data,
    input  logic                  pop_req,
    output logic                  out_valid,
    output logic [BFM_DATA_W-1:0] out_data,
    output logic                  full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [BFM_DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  pop;
    logic                  wr;

    assign out_valid = (count != '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign pop       = pop_req && out_valid;
    // A full buffer can still accept a push when the head leaves this cycle.
    assign wr        = push && (!full || pop);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    // Storage write; contents need no reset because out_valid gates them.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/simple_rsp_bfm.sv
// Responder-side handshake BFM: captures req/data into a receive buffer,
// answers with a one-cycle ack ACK_DELAY cycles after capture and waits for
// req to drop before accepting the next request. Backpressures (no capture,
// no ack) while the buffer is full.
// Optional statistics counters are enabled by defining SIMPLE_RSP_BFM_STATS_EN.
module simple_rsp_bfm
    import simple_bfm_pkg::*;
#(
    parameter int ACK_DELAY  = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic [BFM_DATA_W-1:0] data,
    output logic                  ack,
    output logic                  out_valid,
    output logic [BFM_DATA_W-1:0] out_data,
    input  logic                  out_ready,
    output logic                  busy
`ifdef SIMPLE_RSP_BFM_STATS_EN
    ,
    output logic [BFM_CNT_W-1:0]  req_count,
    output logic [BFM_CNT_W-1:0]  ack_count,
    output logic [BFM_CNT_W-1:0]  stall_count
`endif
);

    localparam logic [3:0] DLY_LOAD = 4'(ACK_DELAY);

    rsp_state_t state;
    rsp_state_t state_next;
    logic [3:0] dly_cnt;
    logic [3:0] dly_cnt_next;
    logic       ack_next;
    logic       push;
    logic       full;
    logic       can_capture;

    // A full buffer only accepts when the consumer pops in the same cycle.
    assign can_capture = !full || out_ready;
    assign busy        = (state != IDLE);

    simple_bfm_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_data(data),
        .pop_req  (out_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .full     (full)
    );

    // Handshake sequencing: next state, delay count, capture strobe and ack.
    always_comb begin
        state_next   = state;
        dly_cnt_next = dly_cnt;
        ack_next     = 1'b0;
        push         = 1'b0;
        case (state)
            IDLE: begin
                if (req && can_capture) begin
                    push = 1'b1;
                    if (ACK_DELAY == 0) begin
                        state_next = ACK;
                        ack_next   = 1'b1;
                    end else begin
                        state_next   = DELAY;
                        dly_cnt_next = DLY_LOAD;
                    end
                end
            end
            DELAY: begin
                if (dly_cnt <= 4'd1) begin
                    state_next   = ACK;
                    ack_next     = 1'b1;
                    dly_cnt_next = '0;
                end else begin
                    dly_cnt_next = dly_cnt - 1'b1;
                end
            end
            ACK: begin
                state_next = RELEASE;
            end
            RELEASE: begin
                if (!req) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, delay counter and registered ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            dly_cnt <= '0;
            ack     <= 1'b0;
        end else begin
            state   <= state_next;
            dly_cnt <= dly_cnt_next;
            ack     <= ack_next;
        end
    end

`ifdef SIMPLE_RSP_BFM_STATS_EN
    logic stall;

    // A stall is an idle cycle where the request is refused for lack of room.
    assign stall = (state == IDLE) && req && !can_capture;

    // Saturating activity counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_count   <= '0;
            ack_count   <= '0;
            stall_count <= '0;
        end else begin
            if (push) begin
                req_count <= sat_inc(req_count);
            end
            if (ack_next) begin
                ack_count <= sat_inc(ack_count);
            end
            if (stall) begin
                stall_count <= sat_inc(stall_count);
            end
        end
    end
`endif

endmodule

// File: tb/tb_simple_rsp_bfm.sv
// Scoreboard bench for simple_rsp_bfm. Two instances share stimulus: one with
// ACK_DELAY=2 and one with ACK_DELAY=0. A reference model in the monitor
// tracks buffer contents and expected ack edges from the handshake rules.
module tb_simple_rsp_bfm;

    localparam int DEPTH = 4;
    localparam int ACK_D = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req;
    logic [7:0] data;
    logic       out_ready;
    logic       ack, out_valid, busy;
    logic [7:0] out_data;
    logic       ack0, out_valid0, busy0;
    logic [7:0] out_data0;
`ifdef SIMPLE_RSP_BFM_STATS_EN
    logic [15:0] req_count, ack_count, stall_count;
    logic [15:0] req_count0, ack_count0, stall_count0;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int edge_cnt = 0;
    int mode     = 0;   // consumer: 0 hold off, 1 random, 2 always ready

    logic [7:0] model_q[$];
    bit         captured = 1'b0;
    int         ack_edge  = -1;
    int         ack0_edge = -1;

    always #5 clk = ~clk;

    simple_rsp_bfm #(.ACK_DELAY(ACK_D), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .data(data), .ack(ack),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy)
`ifdef SIMPLE_RSP_BFM_STATS_EN
        , .req_count(req_count), .ack_count(ack_count), .stall_count(stall_count)
`endif
    );

    simple_rsp_bfm #(.ACK_DELAY(0), .FIFO_DEPTH(DEPTH)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req), .data(data), .ack(ack0),
        .out_valid(out_valid0), .out_data(out_data0), .out_ready(out_ready),
        .busy(busy0)
`ifdef SIMPLE_RSP_BFM_STATS_EN
        , .req_count(req_count0), .ack_count(ack_count0), .stall_count(stall_count0)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Posedge counter used by the model to place expected ack pulses.
    initial forever begin
        @(posedge clk);
        edge_cnt++;
    end

    // Consumer: drives out_ready just after each rising edge.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                1:       out_ready = $urandom_range(0, 1) == 1;
                2:       out_ready = 1'b1;
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor and reference model, evaluated mid-cycle on the values that the
    // coming rising edge will act upon.
    initial forever begin
        int  occ;
        bit  pop_now;
        @(negedge clk);
        if (!rst_n) begin
            model_q.delete();
            captured  = 1'b0;
            ack_edge  = -1;
            ack0_edge = -1;
            check("rst_ack", ack, 0);
            check("rst_out_valid", out_valid, 0);
        end else begin
            check("ack_timing", ack, edge_cnt == ack_edge);
            check("ack0_timing", ack0, edge_cnt == ack0_edge);
            check("out_valid", out_valid, model_q.size() > 0);
            check("out_valid0", out_valid0, model_q.size() > 0);
            check("out_data", out_data, (model_q.size() > 0) ? model_q[0] : 8'h00);
            check("out_data0", out_data0, (model_q.size() > 0) ? model_q[0] : 8'h00);
            occ     = model_q.size();
            pop_now = out_ready && (occ > 0);
            if (pop_now) void'(model_q.pop_front());
            if (!req) begin
                captured = 1'b0;
            end else if (!captured && (occ < DEPTH || pop_now)) begin
                model_q.push_back(data);
                captured  = 1'b1;
                ack_edge  = edge_cnt + 1 + ACK_D;
                ack0_edge = edge_cnt + 1;
            end
        end
    end

    task automatic raise_req(input logic [7:0] d);
        req  = 1'b1;
        data = d;
    endtask

    task automatic wait_ack();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (ack) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL ack_wait: no ack within 300 cycles, expected a pulse at %0t", $time);
    endtask

    // Hold req for 'hold' extra cycles after ack (scrambling data), then drop it
    // for one cycle so the responder is idle again.
    task automatic drop_req(input int hold);
        @(posedge clk);
        #1;
        for (int i = 0; i < hold; i++) begin
            data = 8'($urandom);
            @(posedge clk);
            #1;
        end
        req  = 1'b0;
        data = 8'($urandom);
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [7:0] d, input int hold);
        raise_req(d);
        wait_ack();
        drop_req(hold);
    endtask

    task automatic pop_one_after(input int n);
        repeat (n) @(posedge clk);
        mode = 2;
        @(posedge clk);
        mode = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 1'b0;
        data  = 8'h00;
        #1;
        check("rst_busy", busy, 0);
        check("rst_ack_imm", ack, 0);
        check("rst_ov_imm", out_valid, 0);
        check("rst_od_imm", out_data, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single request into an empty buffer, then fill with consumer off.
        do_req(8'hA5, 0);
        do_req(8'h11, 0);
        do_req(8'h22, 0);
        do_req(8'h33, 0);
        // Fifth request stalls until one pop frees a slot.
        fork
            do_req(8'h44, 0);
            pop_one_after(8);
        join
        // Full buffer: pop and capture on the same edge.
        fork
            do_req(8'h55, 0);
            pop_one_after(3);
        join
        // Hold req high well past ack; must not be captured twice.
        mode = 2;
        repeat (6) @(posedge clk);
        #1;
        do_req(8'h66, 6);

        // Randomized traffic with a random consumer.
        mode = 1;
        for (int i = 0; i < 40; i++) begin
            int gap;
            int hold;
            gap  = $urandom_range(0, 2);
            hold = ($urandom_range(0, 3) == 0) ? 6 : $urandom_range(0, 1);
            for (int g = 0; g < gap; g++) begin
                @(posedge clk);
                #1;
            end
            do_req(8'($urandom), hold);
        end

        // Reset during DELAY, then a still-high req is captured afresh.
        mode = 2;
        repeat (6) @(posedge clk);
        #1;
        raise_req(8'h3C);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ov", out_valid, 0);
        check("mid_rst_od", out_data, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ack", ack, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        data  = 8'hC3;
        wait_ack();
        drop_req(0);

        repeat (12) @(posedge clk);
        #1;
        check("final_empty", out_valid, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
